ssp_tx_ctrl: RTL and testbench
==============================

SSP_TX_CTRL -- requirements
Module: ssp_tx_ctrl

Interface
REQ-001 Parameter DATA_W, default 8, frame width in bits.
REQ-002 Parameter CLK_DIV, default 2, number of PCLK cycles per SSPCLKOUT half-period (>=1).
REQ-003 PCLK  in  1  single system clock; all logic on rising edge.
REQ-004 CLEAR_B  in  1  reset, asynchronous, active-low.
REQ-005 fifo_ready  in  1  transmit FIFO non-empty.
REQ-006 TXDATA  in  DATA_W  FIFO head word, valid while fifo_ready=1.
REQ-007 read  out  1  one-PCLK pop strobe to the FIFO.
REQ-008 SSPCLKOUT  out  1  serial clock.
REQ-009 SSPFSSOUT  out  1  frame sync, high for one bit period before data.
REQ-010 SSPTXD  out  1  serial data, MSB first.
REQ-011 SSPOE_B  out  1  output enable, active-low, low only while shifting data.
REQ-012 busy  out  1  high in any state other than IDLE.

Function
REQ-013 The FSM SHALL have the states IDLE, LOAD, FSYNC and SHIFT.
REQ-014 IDLE->LOAD on the first PCLK edge with fifo_ready=1; read asserts in the cycle after fifo_ready rises (latency 1).
REQ-015 LOAD SHALL last exactly one PCLK, assert read=1, capture TXDATA into the shift register, and clear the divider and bit counters.
REQ-016 read SHALL be high only in LOAD: never two consecutive cycles, never when fifo_ready=0.
REQ-017 Bit period = 2*CLK_DIV PCLK cycles; SSPCLKOUT low in the first half and high in the second half of each bit period in FSYNC and SHIFT, and low otherwise.
REQ-018 FSYNC: SSPFSSOUT=1, SSPOE_B=1, SSPTXD=0 for one bit period, then go to SHIFT.
REQ-019 SHIFT: SSPOE_B=0, SSPFSSOUT=0, SSPTXD = shift register MSB; left shift at each bit-period boundary; 3-bit (clog2 DATA_W) bit counter counts 0..DATA_W-1.
REQ-020 After the last bit period: fifo_ready=1 -> LOAD (back-to-back, no IDLE gap); fifo_ready=0 -> IDLE.
REQ-021 Frame length from LOAD to the end of SHIFT SHALL be 1 + 2*CLK_DIV*(DATA_W+1) PCLK cycles (37 at defaults).
REQ-022 fifo_ready changes during FSYNC/SHIFT SHALL NOT affect the frame in progress; TXDATA is sampled only in LOAD.
REQ-023 Counters SHALL wrap to 0 at terminal count with no overflow state.

Reset
REQ-024 When CLEAR_B=0, asynchronously: state=IDLE, read=0, SSPCLKOUT=0, SSPFSSOUT=0, SSPTXD=0, SSPOE_B=1, busy=0, shift register and counters = 0.
REQ-025 Reset mid-frame SHALL abort the frame with no further read pulse; the aborted word is not retransmitted.
REQ-026 After CLEAR_B deasserts, the first possible read is in the second PCLK cycle.

Structure
REQ-027 The shared package ssp_pkg SHALL hold the state enum ssp_tx_state_t and the DATA_W default constant.
REQ-028 Divider/bit-period timing SHALL be one sub-module, ssp_clk_div, producing half-period and bit-end ticks plus SSPCLKOUT, cleared by LOAD.

Verification
REQ-029 Single word: FIFO holds 8'hA5 and fifo_ready rises -> read high for 1 cycle the next cycle; FSS high 4 cycles; SSPTXD serialises 1,0,1,0,0,1,0,1, 4 cycles each; IDLE 37 cycles after LOAD.
REQ-030 Back-to-back: FIFO holds 8'h3C, 8'hC3 -> second read exactly 37 cycles after the first; no IDLE cycle; busy stays 1 throughout.
REQ-031 Empty FIFO: fifo_ready held 0 for 100 cycles -> read, busy and SSPFSSOUT stay 0, SSPOE_B stays 1.
REQ-032 Mid-frame reset: CLEAR_B=0 during bit 3 -> all outputs take their reset values immediately (asynchronously); no read until fifo_ready is seen after release.
REQ-033 Late drop: fifo_ready falls during SHIFT of 8'hFF -> all 8 bits of 1 are sent, then IDLE.
REQ-034 CLK_DIV=1: 8'h81 -> bit period 2 cycles, frame 19 cycles, SSPCLKOUT toggles every PCLK.

Source files
------------

// File: rtl/ssp_pkg.sv
// Shared types and defaults for the SSP transmit controller.
package ssp_pkg;

   localparam int SSP_DATA_W_DEF  = 8;
   localparam int SSP_CLK_DIV_DEF = 2;

   // Transmit sequencer states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_FSYNC = 2'd2,
      ST_SHIFT = 2'd3
   } ssp_tx_state_t;

   // Observation bundle: sequencer state plus divider ticks
   typedef struct packed {
      ssp_tx_state_t state;
      logic          half_tick;
      logic          bit_end;
   } ssp_tx_dbg_t;

   // Counter width for a modulus n, never narrower than one bit
   function automatic int ssp_cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ssp_clk_div.sv
// Bit-period timing for the SSP transmitter: a CLK_DIV divider feeding a
// phase bit. Phase 0 is the low half of a bit period, phase 1 the high half.
module ssp_clk_div
   import ssp_pkg::*;
#(
   parameter int CLK_DIV = SSP_CLK_DIV_DEF
) (
   input  logic PCLK,
   input  logic CLEAR_B,
   input  logic clr,
   input  logic en,
   output logic half_tick,
   output logic bit_end,
   output logic SSPCLKOUT
);

   localparam int               DIV_W    = ssp_cnt_w(CLK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_cnt;
   logic             phase;

   assign half_tick = en && (div_cnt == DIV_LAST);
   assign bit_end   = half_tick && phase;
   // phase returns to 0 at every bit end, so the serial clock idles low
   assign SSPCLKOUT = phase;

   // Divider counter and half-period phase; cleared at the start of each frame
   always_ff @(posedge PCLK or negedge CLEAR_B) begin
      if (!CLEAR_B) begin
         div_cnt <= '0;
         phase   <= 1'b0;
      end else if (clr) begin
         div_cnt <= '0;
         phase   <= 1'b0;
      end else if (en) begin
         if (half_tick) begin
            div_cnt <= '0;
            phase   <= ~phase;
         end else begin
            div_cnt <= div_cnt + DIV_W'(1);
         end
      end
   end

endmodule

// File: rtl/ssp_tx_ctrl.sv
// SSP transmit controller: pops one word from the transmit FIFO, sends a
// one-bit-period frame sync, then shifts the word out MSB first.
//
// FIFO handshake: fifo_ready is the FIFO's valid (non-empty) and TXDATA its
// head word. read is a one-cycle pop strobe issued only in LOAD; the word is
// captured from TXDATA in that same cycle and the FIFO advances on the edge
// that ends it. read never stays high for two cycles in a row.
module ssp_tx_ctrl
   import ssp_pkg::*;
#(
   parameter int DATA_W  = SSP_DATA_W_DEF,
   parameter int CLK_DIV = SSP_CLK_DIV_DEF
) (
   input  logic              PCLK,
   input  logic              CLEAR_B,
   input  logic              fifo_ready,
   input  logic [DATA_W-1:0] TXDATA,
   output logic              read,
   output logic              SSPCLKOUT,
   output logic              SSPFSSOUT,
   output logic              SSPTXD,
   output logic              SSPOE_B,
   output logic              busy,
   output ssp_tx_dbg_t       dbg
);

   localparam int               BIT_W    = ssp_cnt_w(DATA_W);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

   ssp_tx_state_t     state;
   logic [DATA_W-1:0] shreg;
   logic [BIT_W-1:0]  bit_cnt;
   logic              div_clr;
   logic              div_en;
   logic              half_tick;
   logic              bit_end;

   assign div_clr = (state == ST_LOAD);
   assign div_en  = (state == ST_FSYNC) || (state == ST_SHIFT);

   ssp_clk_div #(
      .CLK_DIV (CLK_DIV)
   ) u_clk_div (
      .PCLK      (PCLK),
      .CLEAR_B   (CLEAR_B),
      .clr       (div_clr),
      .en        (div_en),
      .half_tick (half_tick),
      .bit_end   (bit_end),
      .SSPCLKOUT (SSPCLKOUT)
   );

   assign dbg = '{state: state, half_tick: half_tick, bit_end: bit_end};

   // Sequencer with registered outputs: every output is set on the edge that
   // enters the state it belongs to.
   always_ff @(posedge PCLK or negedge CLEAR_B) begin
      if (!CLEAR_B) begin
         state     <= ST_IDLE;
         read      <= 1'b0;
         SSPFSSOUT <= 1'b0;
         SSPTXD    <= 1'b0;
         SSPOE_B   <= 1'b1;
         busy      <= 1'b0;
         shreg     <= '0;
         bit_cnt   <= '0;
      end else begin
         read <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (fifo_ready) begin
                  state <= ST_LOAD;
                  read  <= 1'b1;
                  busy  <= 1'b1;
               end
            end
            ST_LOAD: begin
               shreg     <= TXDATA;
               bit_cnt   <= '0;
               state     <= ST_FSYNC;
               SSPFSSOUT <= 1'b1;
               SSPOE_B   <= 1'b1;
               SSPTXD    <= 1'b0;
            end
            ST_FSYNC: begin
               if (bit_end) begin
                  state     <= ST_SHIFT;
                  SSPFSSOUT <= 1'b0;
                  SSPOE_B   <= 1'b0;
                  SSPTXD    <= shreg[DATA_W-1];
               end
            end
            ST_SHIFT: begin
               if (bit_end) begin
                  if (bit_cnt == BIT_LAST) begin
                     // Frame done: chain straight into the next word if one waits
                     bit_cnt <= '0;
                     SSPOE_B <= 1'b1;
                     SSPTXD  <= 1'b0;
                     if (fifo_ready) begin
                        state <= ST_LOAD;
                        read  <= 1'b1;
                     end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + BIT_W'(1);
                     shreg   <= {shreg[DATA_W-2:0], 1'b0};
                     SSPTXD  <= shreg[DATA_W-2];
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ssp_tx_ctrl.sv
// Directed bench for ssp_tx_ctrl: a checkpoint table for a single frame plus
// hand-written sequences for back-to-back, late drop, reset and CLK_DIV=1.
module tb_ssp_tx_ctrl;
   import ssp_pkg::*;

   localparam int DW = 8;

   typedef struct {
      int   k;
      logic rd;
      logic bsy;
      logic fss;
      logic oeb;
      logic txd;
      logic sclk;
   } chk_t;

   logic          PCLK = 1'b0;
   logic          CLEAR_B = 1'b1;

   logic          fifo_ready = 1'b0;
   logic [DW-1:0] TXDATA = '0;
   logic          read, SSPCLKOUT, SSPFSSOUT, SSPTXD, SSPOE_B, busy;
   ssp_tx_dbg_t   dbg;

   logic          fifo_ready1 = 1'b0;
   logic [DW-1:0] TXDATA1 = '0;
   logic          read1, SSPCLKOUT1, SSPFSSOUT1, SSPTXD1, SSPOE_B1, busy1;
   ssp_tx_dbg_t   dbg1;

   int            n_checks = 0;
   int            n_fail = 0;
   logic [DW-1:0] fifo_q[$];
   logic [DW-1:0] exp_q[$];
   bit            use_model = 1'b1;
   bit            sel1 = 1'b0;
   bit            prev_read = 1'b0;
   int            waited;

   logic          cap_read [0:99];
   logic          cap_busy [0:99];
   logic          cap_fss  [0:99];
   logic          cap_oeb  [0:99];
   logic          cap_txd  [0:99];
   logic          cap_sclk [0:99];
   ssp_tx_state_t cap_state[0:99];

   chk_t          tbl[15];

   ssp_tx_ctrl #(.DATA_W(DW), .CLK_DIV(2)) u_dut (
      .PCLK       (PCLK),
      .CLEAR_B    (CLEAR_B),
      .fifo_ready (fifo_ready),
      .TXDATA     (TXDATA),
      .read       (read),
      .SSPCLKOUT  (SSPCLKOUT),
      .SSPFSSOUT  (SSPFSSOUT),
      .SSPTXD     (SSPTXD),
      .SSPOE_B    (SSPOE_B),
      .busy       (busy),
      .dbg        (dbg)
   );

   ssp_tx_ctrl #(.DATA_W(DW), .CLK_DIV(1)) u_dut1 (
      .PCLK       (PCLK),
      .CLEAR_B    (CLEAR_B),
      .fifo_ready (fifo_ready1),
      .TXDATA     (TXDATA1),
      .read       (read1),
      .SSPCLKOUT  (SSPCLKOUT1),
      .SSPFSSOUT  (SSPFSSOUT1),
      .SSPTXD     (SSPTXD1),
      .SSPOE_B    (SSPOE_B1),
      .busy       (busy1),
      .dbg        (dbg1)
   );

   // Clock
   always #5 PCLK = ~PCLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic refresh();
      if (use_model) begin
         fifo_ready = (fifo_q.size() != 0);
         if (fifo_q.size() != 0) TXDATA = fifo_q[0];
         else TXDATA = '0;
      end
   endtask

   task automatic push(input logic [DW-1:0] w);
      fifo_q.push_back(w);
      exp_q.push_back(w);
      refresh();
   endtask

   function automatic logic cur_read();
      return sel1 ? read1 : read;
   endfunction

   // Advance one cycle; the FIFO model pops on the edge that ends a read cycle
   task automatic step();
      @(posedge PCLK);
      #1;
      if (use_model && prev_read && fifo_q.size() != 0) void'(fifo_q.pop_front());
      refresh();
      prev_read = cur_read();
   endtask

   task automatic wait_read(input string name);
      bit ok;
      ok = 1'b0;
      waited = 0;
      for (int i = 0; i < 200; i++) begin
         if (cur_read()) begin
            ok = 1'b1;
            break;
         end
         step();
         waited++;
      end
      check(name, ok, 1);
   endtask

   // Record n cycles of outputs, index 0 being the LOAD (read) cycle
   task automatic capture(input int n, input int drop_k);
      for (int k = 0; k < n; k++) begin
         cap_read[k]  = sel1 ? read1      : read;
         cap_busy[k]  = sel1 ? busy1      : busy;
         cap_fss[k]   = sel1 ? SSPFSSOUT1 : SSPFSSOUT;
         cap_oeb[k]   = sel1 ? SSPOE_B1   : SSPOE_B;
         cap_txd[k]   = sel1 ? SSPTXD1    : SSPTXD;
         cap_sclk[k]  = sel1 ? SSPCLKOUT1 : SSPCLKOUT;
         cap_state[k] = sel1 ? dbg1.state : dbg.state;
         if (!use_model && k == 1) begin
            if (sel1) TXDATA1 = '0;
            else TXDATA = '0;
         end
         if (!use_model && k == drop_k) begin
            if (sel1) fifo_ready1 = 1'b0;
            else fifo_ready = 1'b0;
         end
         if (k < n - 1) step();
      end
   endtask

   function automatic logic [DW-1:0] decode(input int base, input int first, input int period);
      logic [DW-1:0] w;
      for (int i = 0; i < DW; i++) w[DW-1-i] = cap_txd[base + first + period * i];
      return w;
   endfunction

   function automatic int count_reads(input int from, input int upto);
      int c;
      c = 0;
      for (int k = from; k <= upto; k++) if (cap_read[k] === 1'b1) c++;
      return c;
   endfunction

   initial begin
      int bad_rd, bad_busy, bad_fss, bad_oe, r2, errs, nfss;

      // k, read, busy, fss, oe_b, txd, sclk  -- frame of 8'hA5 at CLK_DIV=2
      tbl[0]  = '{0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[1]  = '{1,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[2]  = '{3,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[3]  = '{4,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[4]  = '{5,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[5]  = '{7,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[6]  = '{9,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[7]  = '{13, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[8]  = '{17, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[9]  = '{21, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[10] = '{26, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[11] = '{29, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[12] = '{35, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[13] = '{36, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[14] = '{37, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

      // Reset values, checked before the first clock edge
      #1 CLEAR_B = 1'b0;
      #2;
      check("rst_read", read, 0);
      check("rst_sclk", SSPCLKOUT, 0);
      check("rst_fss", SSPFSSOUT, 0);
      check("rst_txd", SSPTXD, 0);
      check("rst_oe_b", SSPOE_B, 1);
      check("rst_busy", busy, 0);
      check("rst_state", dbg.state, ST_IDLE);
      check("rst_busy1", busy1, 0);
      repeat (3) step();
      check("rst_hold_state", dbg.state, ST_IDLE);
      #2 CLEAR_B = 1'b1;

      // Empty FIFO for 100 cycles
      bad_rd = 0; bad_busy = 0; bad_fss = 0; bad_oe = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (read !== 1'b0) bad_rd++;
         if (busy !== 1'b0) bad_busy++;
         if (SSPFSSOUT !== 1'b0) bad_fss++;
         if (SSPOE_B !== 1'b1) bad_oe++;
      end
      check("empty_read", bad_rd, 0);
      check("empty_busy", bad_busy, 0);
      check("empty_fss", bad_fss, 0);
      check("empty_oe_b", bad_oe, 0);

      // Single word 8'hA5 against the checkpoint table
      push(8'hA5);
      wait_read("a5_read_seen");
      check("a5_read_latency", waited, 1);
      capture(40, -1);
      for (int t = 0; t < 15; t++) begin
         check($sformatf("a5_read_k%0d", tbl[t].k), cap_read[tbl[t].k], tbl[t].rd);
         check($sformatf("a5_busy_k%0d", tbl[t].k), cap_busy[tbl[t].k], tbl[t].bsy);
         check($sformatf("a5_fss_k%0d", tbl[t].k), cap_fss[tbl[t].k], tbl[t].fss);
         check($sformatf("a5_oe_b_k%0d", tbl[t].k), cap_oeb[tbl[t].k], tbl[t].oeb);
         check($sformatf("a5_txd_k%0d", tbl[t].k), cap_txd[tbl[t].k], tbl[t].txd);
         check($sformatf("a5_sclk_k%0d", tbl[t].k), cap_sclk[tbl[t].k], tbl[t].sclk);
      end
      check("a5_word", decode(0, 5, 4), exp_q.pop_front());
      check("a5_single_read", count_reads(1, 39), 0);
      check("a5_last_shift", cap_state[36], ST_SHIFT);
      check("a5_idle_at_37", cap_state[37], ST_IDLE);

      // Back-to-back 8'h3C, 8'hC3
      push(8'h3C);
      push(8'hC3);
      wait_read("b2b_read_seen");
      capture(80, -1);
      r2 = -1;
      for (int k = 1; k < 80; k++) if (r2 < 0 && cap_read[k] === 1'b1) r2 = k;
      check("b2b_second_read", r2, 37);
      errs = 0;
      for (int k = 0; k <= 73; k++) if (cap_busy[k] !== 1'b1) errs++;
      check("b2b_busy_gaps", errs, 0);
      check("b2b_load_state", cap_state[37], ST_LOAD);
      check("b2b_word0", decode(0, 5, 4), exp_q.pop_front());
      check("b2b_word1", decode(37, 5, 4), exp_q.pop_front());
      check("b2b_reads", count_reads(0, 79), 2);
      check("b2b_idle_after", cap_busy[74], 0);

      // Late drop: fifo_ready held through FSYNC, falls mid-SHIFT of 8'hFF
      use_model = 1'b0;
      fifo_ready = 1'b1;
      TXDATA = 8'hFF;
      exp_q.push_back(8'hFF);
      wait_read("drop_read_seen");
      capture(40, 10);
      check("drop_word", decode(0, 5, 4), exp_q.pop_front());
      check("drop_no_reread", count_reads(1, 39), 0);
      check("drop_busy_end", cap_busy[37], 0);
      check("drop_idle", cap_state[38], ST_IDLE);
      use_model = 1'b1;
      prev_read = 1'b0;
      refresh();

      // Reset in the high half of bit 3 of 8'h5A
      push(8'h5A);
      wait_read("rst_mid_read_seen");
      repeat (19) step();
      check("pre_rst_txd", SSPTXD, 1);
      check("pre_rst_sclk", SSPCLKOUT, 1);
      #2 CLEAR_B = 1'b0;
      #1;
      check("mid_rst_read", read, 0);
      check("mid_rst_sclk", SSPCLKOUT, 0);
      check("mid_rst_fss", SSPFSSOUT, 0);
      check("mid_rst_txd", SSPTXD, 0);
      check("mid_rst_oe_b", SSPOE_B, 1);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_state", dbg.state, ST_IDLE);
      void'(exp_q.pop_front());
      repeat (3) step();
      check("in_rst_read", read, 0);
      push(8'h99);
      step();
      check("in_rst_ready_read", read, 0);
      #2 CLEAR_B = 1'b1;
      step();
      check("post_rst_first_read", read, 1);
      capture(40, -1);
      check("post_rst_word", decode(0, 5, 4), exp_q.pop_front());
      check("post_rst_idle", cap_busy[37], 0);

      // CLK_DIV=1 instance, word 8'h81
      sel1 = 1'b1;
      use_model = 1'b0;
      fifo_ready1 = 1'b1;
      TXDATA1 = 8'h81;
      exp_q.push_back(8'h81);
      wait_read("div1_read_seen");
      capture(22, 1);
      check("div1_word", decode(0, 3, 2), exp_q.pop_front());
      errs = 0;
      for (int k = 1; k <= 18; k++) if (cap_sclk[k] !== ((k % 2) == 0)) errs++;
      check("div1_sclk_toggle", errs, 0);
      nfss = 0;
      for (int k = 0; k < 22; k++) if (cap_fss[k] === 1'b1) nfss++;
      check("div1_fss_cycles", nfss, 2);
      check("div1_busy_k18", cap_busy[18], 1);
      check("div1_busy_k19", cap_busy[19], 0);
      check("div1_idle_k19", cap_state[19], ST_IDLE);
      check("div1_single_read", count_reads(1, 21), 0);
      sel1 = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
